tpu_output_buffer: RTL and testbench
====================================

# tpu_output_buffer

Double-banked result capture buffer at the output edge of the TPU systolic array. It accepts streamed result vectors (one accumulator row per beat) from the array into the active bank. Meanwhile the host/DMA side reads completed results out of the inactive bank over a registered random-access port. It is the return-path counterpart of the activation streaming buffer: array writes sequentially, host reads by address, banks swap to overlap compute with drain.

## Interface
- ARRAY_SIZE, 8, lanes per result vector
- ACC_BITS, 32, bits per lane (signed two's complement)
- MAX_M, 256, depth of each bank in vectors
- ADDR_WIDTH, 16, host read address width; only low $clog2(MAX_M) bits used
- Reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- swap_banks  in  1  pulse: toggle active bank
- capture_start  in  1  pulse: begin capture into active bank
- capture_count  in  $clog2(MAX_M)+1  vectors to capture, 0..MAX_M
- in_valid  in  1  result beat valid from array
- in_data  in  ARRAY_SIZE*ACC_BITS  packed result vector, lane 0 in LSBs
- in_ready  out  1  high while capturing
- capture_busy  out  1  high in S_CAPTURE
- capture_done  out  1  one-cycle pulse at end of capture
- wr_count  out  $clog2(MAX_M)+1  vectors written in current/last capture
- drop_err  out  1  sticky: beat arrived while not capturing
- active_bank  out  1  bank currently owned by the array
- rd_en  in  1  host read request
- rd_addr  in  ADDR_WIDTH  host read address
- rd_data  out  ARRAY_SIZE*ACC_BITS  read data from inactive bank
- rd_valid  out  1  rd_data valid, 1 cycle after rd_en
- relu_en  in  1  present only with TPU_OUTBUF_RELU_EN

## Operation
- Banks: two arrays of MAX_M x (ARRAY_SIZE*ACC_BITS). The array writes bank[active_bank]. The host reads bank[~active_bank]. No write/read collision is possible. Memories are not reset.
- FSM states are S_IDLE, S_CAPTURE and S_DONE.
  - S_IDLE: on capture_start, clear wr_count and drop_err. If capture_count==0, go to S_DONE; else latch target=capture_count and go to S_CAPTURE.
  - S_CAPTURE: each in_valid beat writes in_data to bank[active_bank][wr_count], then wr_count++. The beat that makes wr_count==target goes to S_DONE.
  - S_DONE: capture_done=1 for one cycle, then go to S_IDLE.
- capture_start outside S_IDLE is ignored.
- swap_banks toggles active_bank in S_IDLE or S_DONE and is ignored in S_CAPTURE. If swap_banks and capture_start occur in the same S_IDLE cycle, the toggle applies and the capture writes the new active bank.
- drop_err is set by in_valid when state!=S_CAPTURE. It is cleared only by an accepted capture_start; if both happen in the same cycle, set wins. The dropped beat is never written.
- Host read: on rd_en, register bank[~active_bank][rd_addr[$clog2(MAX_M)-1:0]] into rd_data and assert rd_valid next cycle. The bank select is sampled in the rd_en cycle, so a swap in that same cycle does not affect the returned data. rd_data holds its value when rd_en is low.

## Timing
- Reset values of all outputs: in_ready=0, capture_busy=0, capture_done=0, wr_count=0, drop_err=0, active_bank=0, rd_data=0, rd_valid=0. FSM resets to S_IDLE.
- Capture latency: capture_start at cycle T means in_ready=1 from T+1. The last beat is accepted at cycle L, and capture_done=1 at L+1.
- capture_count=0: capture_done is asserted at T+1 with no writes.
- Beats may have gaps (in_valid low); the capture waits indefinitely. There is no backpressure: in_ready is informational and the array must not send beats while it is low.
- Read latency is 1 cycle. Back-to-back rd_en gives one result per cycle.
- wr_count reaching MAX_M is legal; there is no wrap within a capture.
- Reset mid-capture returns immediately to S_IDLE with active_bank=0. Partially written data remains in memory, but wr_count reads 0.

## Configuration
- TPU_OUTBUF_RELU_EN defined: the relu_en port exists. When relu_en=1 on a beat, each lane with its MSB set is written as 0; other lanes are written verbatim. relu_en is sampled per beat.
- TPU_OUTBUF_RELU_EN undefined: the relu_en port is absent, and all data is stored verbatim.

## Test plan
- Capture 4 vectors: capture_start with count=4, beats lane0=1..4, capture_done at cycle L+1. Then swap_banks and read addr 0..3; the response is rd_data lane0=1,2,3,4, each valid 1 cycle after rd_en.
- Ping-pong: capture A into bank0, swap, capture B into bank1 while the host reads bank0. The reads return A values only and active_bank=1.
- Stray beat in S_IDLE: drop_err=1 and memory is unchanged. The next capture_start clears drop_err to 0.
- Zero count and gaps: count=0 gives capture_done one cycle after start with wr_count=0. Count=3 with idle cycles between beats gives done only after the third beat.
- Reset asserted after 2 of 5 beats: all outputs take their reset values and the FSM is in S_IDLE. A new capture with count=2 then completes normally.
- ReLU, with TPU_OUTBUF_RELU_EN and relu_en=1: a lane of -5 reads back 0 and a lane of 7 reads back 7. With relu_en=0, -5 reads back -5.

Source files
------------

// File: rtl/tpu_output_buffer.sv
// Double-banked result capture buffer: the systolic array streams rows into the active bank while the host reads the other one.
// Optional ReLU on write is enabled by defining TPU_OUTBUF_RELU_EN (adds the relu_en port).
module tpu_output_buffer #(
  parameter int ARRAY_SIZE = 8,
  parameter int ACC_BITS   = 32,
  parameter int MAX_M      = 256,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                swap_banks,
  input  logic                                capture_start,
  input  logic [$clog2(MAX_M):0]              capture_count,
  input  logic                                in_valid,
  input  logic [ARRAY_SIZE*ACC_BITS-1:0]      in_data,
  output logic                                in_ready,
  output logic                                capture_busy,
  output logic                                capture_done,
  output logic [$clog2(MAX_M):0]              wr_count,
  output logic                                drop_err,
  output logic                                active_bank,
  input  logic                                rd_en,
  input  logic [ADDR_WIDTH-1:0]               rd_addr,
  output logic [ARRAY_SIZE*ACC_BITS-1:0]      rd_data,
  output logic                                rd_valid
`ifdef TPU_OUTBUF_RELU_EN
  ,
  input  logic                                relu_en
`endif
);

  localparam int AW = $clog2(MAX_M);
  localparam int CW = AW + 1;
  localparam int DW = ARRAY_SIZE * ACC_BITS;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   target_reg;
  logic [CW-1:0]   wr_count_reg;
  logic [CW-1:0]   wr_count_inc;
  logic            active_bank_reg;
  logic            drop_err_reg;
  logic            rd_valid_reg;
  logic [DW-1:0]   rd_data_reg;
  logic [DW-1:0]   wr_data;
  logic            beat_wr;
  logic            start_ok;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_idx;

  logic [DW-1:0]   mem0 [MAX_M];
  logic [DW-1:0]   mem1 [MAX_M];

  assign beat_wr      = (state_reg == S_CAPTURE) && in_valid;
  assign start_ok     = (state_reg == S_IDLE) && capture_start;
  assign wr_count_inc = wr_count_reg + CW'(1);
  assign wr_addr      = wr_count_reg[AW-1:0];
  assign rd_idx       = rd_addr[AW-1:0];

  generate
    if (ADDR_WIDTH > AW) begin : g_addr_hi
      logic unused_rd_addr_hi;
      assign unused_rd_addr_hi = ^rd_addr[ADDR_WIDTH-1:AW];
    end
  endgenerate

  // Per-lane write data; negative lanes are clamped to zero when ReLU is requested on the beat.
  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
      logic [ACC_BITS-1:0] lane;
      assign lane = in_data[gi*ACC_BITS +: ACC_BITS];
`ifdef TPU_OUTBUF_RELU_EN
      assign wr_data[gi*ACC_BITS +: ACC_BITS] = (relu_en && lane[ACC_BITS-1]) ? '0 : lane;
`else
      assign wr_data[gi*ACC_BITS +: ACC_BITS] = lane;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_ok) begin
          state_next = (capture_count == '0) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (in_valid && (wr_count_inc == target_reg)) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_reg      <= '0;
      wr_count_reg    <= '0;
      active_bank_reg <= 1'b0;
      drop_err_reg    <= 1'b0;
    end else begin
      if (start_ok) begin
        target_reg   <= capture_count;
        wr_count_reg <= '0;
      end else if (beat_wr) begin
        wr_count_reg <= wr_count_inc;
      end
      // Banks only swap while the array is not mid-capture.
      if (swap_banks && (state_reg != S_CAPTURE)) begin
        active_bank_reg <= ~active_bank_reg;
      end
      // A stray beat in the same cycle as an accepted start still flags.
      if (in_valid && (state_reg != S_CAPTURE)) begin
        drop_err_reg <= 1'b1;
      end else if (start_ok) begin
        drop_err_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr && !active_bank_reg) begin
      mem0[wr_addr] <= wr_data;
    end
    if (beat_wr && active_bank_reg) begin
      mem1[wr_addr] <= wr_data;
    end
  end

  // Host always reads the bank the array does not own, selected in the request cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_data_reg <= active_bank_reg ? mem0[rd_idx] : mem1[rd_idx];
      end
    end
  end

  assign in_ready     = (state_reg == S_CAPTURE);
  assign capture_busy = (state_reg == S_CAPTURE);
  assign capture_done = (state_reg == S_DONE);
  assign wr_count     = wr_count_reg;
  assign drop_err     = drop_err_reg;
  assign active_bank  = active_bank_reg;
  assign rd_data      = rd_data_reg;
  assign rd_valid     = rd_valid_reg;

endmodule

// File: tb/tb_tpu_output_buffer.sv
// Self-checking bench for tpu_output_buffer: table-driven captures plus hand sequences; reads go through a scoreboard queue.
// Define TPU_OUTBUF_RELU_EN to also exercise the ReLU option.
module tb_tpu_output_buffer;
  localparam int AS  = 8;
  localparam int AB  = 32;
  localparam int MM  = 256;
  localparam int AWD = 16;
  localparam int CW  = 9;
  localparam int DW  = AS * AB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          swap_banks = 1'b0;
  logic          capture_start = 1'b0;
  logic [CW-1:0] capture_count = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          relu_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AWD-1:0] rd_addr = '0;
  logic          in_ready, capture_busy, capture_done, drop_err, active_bank, rd_valid;
  logic [CW-1:0] wr_count;
  logic [DW-1:0] rd_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] model [2][MM];
  logic          exp_bank = 1'b0;
  logic [DW-1:0] rd_q[$];
  logic          exp_rd_valid = 1'b0;
  logic [DW-1:0] last_rd = '0;

  tpu_output_buffer #(.ARRAY_SIZE(AS), .ACC_BITS(AB), .MAX_M(MM), .ADDR_WIDTH(AWD)) dut (
    .clk(clk), .rst_n(rst_n), .swap_banks(swap_banks), .capture_start(capture_start),
    .capture_count(capture_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .capture_busy(capture_busy), .capture_done(capture_done),
    .wr_count(wr_count), .drop_err(drop_err), .active_bank(active_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
`ifdef TPU_OUTBUF_RELU_EN
    , .relu_en(relu_en)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Lane 0 carries the beat value; odd lanes are negative so ReLU has something to clamp.
  function automatic logic [DW-1:0] make_vec(input logic [31:0] v);
    logic [DW-1:0] d;
    for (int l = 0; l < AS; l++) begin
      if (l == 0) d[l*AB +: AB] = v;
      else if (l % 2 == 1) d[l*AB +: AB] = -(v + 32'(l));
      else d[l*AB +: AB] = v + 32'(l << 20);
    end
    return d;
  endfunction

  function automatic logic [DW-1:0] stored(input logic [DW-1:0] d, input bit relu);
    logic [DW-1:0] r;
    r = d;
    for (int l = 0; l < AS; l++) begin
      if (relu && d[l*AB + AB - 1]) r[l*AB +: AB] = '0;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_rd_valid <= 1'b0;
    else exp_rd_valid <= rd_en;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_valid", rd_valid, exp_rd_valid);
      if (exp_rd_valid) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_scoreboard: got read response expected none");
        end else begin
          last_rd = rd_q.pop_front();
          chk("rd_data", rd_data, last_rd);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, capture_busy, 0);
    chk({tag, "_done"}, capture_done, 0);
    chk({tag, "_wr_count"}, wr_count, 0);
    chk({tag, "_drop_err"}, drop_err, 0);
    chk({tag, "_active_bank"}, active_bank, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
  endtask

  task automatic do_capture(input int cnt, input logic [31:0] base, input int gap, input bit relu);
    int b;
    b = exp_bank ? 1 : 0;
    capture_count = CW'(cnt);
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
    chk("wr_count_clear", wr_count, 0);
    if (cnt == 0) begin
      chk("zero_done", capture_done, 1);
      chk("zero_in_ready", in_ready, 0);
      tick();
      chk("zero_done_pulse", capture_done, 0);
      chk("zero_wr_count", wr_count, 0);
      return;
    end
    chk("cap_in_ready", in_ready, 1);
    chk("cap_busy", capture_busy, 1);
    chk("cap_no_done", capture_done, 0);
    for (int i = 0; i < cnt; i++) begin
      repeat (gap) begin
        tick();
        chk("gap_no_done", capture_done, 0);
        chk("gap_in_ready", in_ready, 1);
      end
      in_data = make_vec(32'(base + 32'(i)));
      relu_en = relu;
      model[b][i] = stored(in_data, relu);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      relu_en = 1'b0;
      chk("beat_wr_count", wr_count, DW'(i + 1));
      if (i == cnt - 1) begin
        chk("last_done", capture_done, 1);
        chk("last_in_ready", in_ready, 0);
      end else begin
        chk("mid_no_done", capture_done, 0);
      end
    end
    tick();
    chk("done_pulse", capture_done, 0);
    chk("wr_count_hold", wr_count, DW'(cnt));
  endtask

  task automatic do_swap();
    swap_banks = 1'b1;
    tick();
    swap_banks = 1'b0;
    exp_bank = ~exp_bank;
    chk("swap_bank", active_bank, DW'(exp_bank));
  endtask

  task automatic read_range(input int bank, input int n, input logic [7:0] hi);
    for (int a = 0; a < n; a++) begin
      rd_en = 1'b1;
      rd_addr = {hi, 8'(a)};
      rd_q.push_back(model[bank][a]);
      tick();
    end
    rd_en = 1'b0;
  endtask

  typedef struct {
    int          count;
    logic [31:0] base;
    int          gap;
    bit          relu;
    int          exp_wr;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{count: 4,   base: 32'd1,          gap: 0, relu: 1'b0, exp_wr: 4};
    tbl[1] = '{count: 0,   base: 32'd0,          gap: 0, relu: 1'b0, exp_wr: 0};
    tbl[2] = '{count: 3,   base: 32'd100,        gap: 2, relu: 1'b0, exp_wr: 3};
    tbl[3] = '{count: 256, base: 32'h1000,       gap: 0, relu: 1'b0, exp_wr: 256};
`ifdef TPU_OUTBUF_RELU_EN
    tbl[4] = '{count: 2,   base: 32'h7fff_fff0,  gap: 1, relu: 1'b1, exp_wr: 2};
`else
    tbl[4] = '{count: 2,   base: 32'h7fff_fff0,  gap: 1, relu: 1'b0, exp_wr: 2};
`endif

    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) begin
      do_capture(tbl[t].count, tbl[t].base, tbl[t].gap, tbl[t].relu);
      chk("tbl_wr_count", wr_count, DW'(tbl[t].exp_wr));
      do_swap();
      read_range(exp_bank ? 0 : 1, tbl[t].count, 8'(t));
      repeat (2) tick();
      if (tbl[t].count > 0) chk("rd_hold", rd_data, last_rd);
    end

    // Ping-pong: capture into bank 1 while the host drains bank 0.
    if (exp_bank) do_swap();
    do_capture(4, 32'hA00, 0, 1'b0);
    do_swap();
    fork
      do_capture(4, 32'hB00, 1, 1'b0);
      read_range(0, 4, 8'h00);
    join
    chk("pp_active_bank", active_bank, 1);
    // A swap in the same cycle as a read must not change the returned bank.
    rd_en = 1'b1;
    rd_addr = 16'd2;
    swap_banks = 1'b1;
    rd_q.push_back(model[0][2]);
    tick();
    rd_en = 1'b0;
    swap_banks = 1'b0;
    exp_bank = 1'b0;
    chk("rdswap_bank", active_bank, 0);
    read_range(1, 4, 8'h00);
    repeat (2) tick();

    // Stray beat while idle: flagged, never written, cleared by the next start.
    in_data = {DW/32{32'hDEAD_BEEF}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("stray_drop_err", drop_err, 1);
    chk("stray_in_ready", in_ready, 0);
    do_swap();
    chk("stray_sticky", drop_err, 1);
    read_range(0, 1, 8'h00);
    repeat (2) tick();
    do_capture(2, 32'hD00, 0, 1'b0);
    chk("drop_cleared", drop_err, 0);

    // Stray beat coinciding with an accepted start: set wins.
    capture_count = '0;
    capture_start = 1'b1;
    in_valid = 1'b1;
    tick();
    capture_start = 1'b0;
    in_valid = 1'b0;
    chk("setwins_drop", drop_err, 1);
    chk("setwins_done", capture_done, 1);
    tick();
    chk("setwins_sticky", drop_err, 1);

    // Reset after 2 of 5 beats; swap and restart mid-capture are ignored.
    if (!exp_bank) do_swap();
    capture_count = CW'(5);
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = make_vec(32'h500 + 32'(i));
      in_valid = 1'b1;
      if (i == 1) begin
        swap_banks = 1'b1;
        capture_start = 1'b1;
        capture_count = CW'(3);
      end
      tick();
      in_valid = 1'b0;
      swap_banks = 1'b0;
      capture_start = 1'b0;
    end
    chk("midcap_bank", active_bank, 1);
    chk("midcap_wr_count", wr_count, 2);
    chk("midcap_busy", capture_busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_bank = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_capture(2, 32'hC00, 0, 1'b0);
    do_swap();
    read_range(0, 2, 8'h00);
    repeat (2) tick();

`ifdef TPU_OUTBUF_RELU_EN
    // ReLU sampled per beat: clamp on the first beat only.
    capture_count = CW'(2);
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
    in_data = '0;
    in_data[31:0] = 32'hFFFF_FFFB;
    in_data[63:32] = 32'd7;
    relu_en = 1'b1;
    in_valid = 1'b1;
    tick();
    relu_en = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("relu_done", capture_done, 1);
    do_swap();
    rd_en = 1'b1;
    rd_addr = 16'd0;
    rd_q.push_back({192'd0, 32'd7, 32'd0});
    tick();
    rd_addr = 16'd1;
    rd_q.push_back({192'd0, 32'd7, 32'hFFFF_FFFB});
    tick();
    rd_en = 1'b0;
    repeat (2) tick();
`endif

    repeat (3) tick();
    chk("rd_queue_empty", DW'(rd_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
